// File: rtl/sram_pkg.sv
// Shared definitions for the internal SRAM request interface and its block-RAM responder.
package sram_pkg;

    localparam int SRAM_DW  = 16;
    localparam int SRAM_BEW = 2;
    localparam int SRAM_AW  = 18;

    localparam logic [SRAM_DW-1:0] OOR_FILL = 16'h0000;

    typedef enum logic [1:0] {
        RST,
        ACCEPT,
        WAIT
    } resp_state_e;

endpackage

// File: rtl/sram_bram_array.sv
// Single-port 2**AW x 16 scratch memory with per-byte write enables and a registered read port.
module sram_bram_array
    import sram_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [SRAM_BEW-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [SRAM_DW-1:0]  wr_data,
    output logic [SRAM_DW-1:0]  rd_data
);

    logic [SRAM_DW-1:0] mem [2**AW];

    // NOTE: neither the array nor its read register has a reset; a reset term would stop the block-RAM mapping.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < SRAM_BEW; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/sram_bram_responder.sv
// Block-RAM responder for the internal SRAM request port, with programmable wait states and read latency.
module sram_bram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_AW,
    parameter int MEM_AW      = 12,
    parameter int RD_LAT      = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                sram_req,
    output logic                sram_ready,
    input  logic                sram_rd,
    input  logic [ADDR_W-1:0]   sram_addr,
    input  logic [SRAM_BEW-1:0] sram_be,
    input  logic [SRAM_DW-1:0]  sram_wr_data,
    output logic                sram_rd_data_vld,
    output logic [SRAM_DW-1:0]  sram_rd_data,
    output logic                oor_err,
    input  logic                oor_clr
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("sram_bram_responder: RD_LAT must be in 1..4");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
        $error("sram_bram_responder: WAIT_STATES must be in 0..7");
    end
    if (MEM_AW > ADDR_W) begin : g_bad_mem_aw
        $error("sram_bram_responder: MEM_AW must not exceed ADDR_W");
    end

    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    resp_state_e       state_d, state_q;
    logic [2:0]        wait_cnt_d, wait_cnt_q;
    logic              ready_d, ready_q;
    logic              oor_err_d, oor_err_q;
    logic [RD_LAT-1:0] vld_d, vld_q;
    logic              rd_oor_d, rd_oor_q;
    logic              xfer, rd_xfer, wr_xfer, addr_oor;
    logic [SRAM_DW-1:0] bram_rd_data, stage0_data, pipe_out;

    assign xfer     = sram_req && ready_q;
    assign addr_oor = (sram_addr >> MEM_AW) != '0;
    assign rd_xfer  = xfer && sram_rd;
    assign wr_xfer  = xfer && !sram_rd && !addr_oor;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RST:    state_d = ACCEPT;
            ACCEPT: begin
                if (xfer && (WAIT_STATES > 0)) begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ACCEPT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            default: state_d = RST;
        endcase
        ready_d = (state_d == ACCEPT);

        // A new out-of-range transfer beats a simultaneous clear.
        oor_err_d = oor_err_q;
        if (xfer && addr_oor) begin
            oor_err_d = 1'b1;
        end else if (oor_clr) begin
            oor_err_d = 1'b0;
        end

        vld_d    = vld_q << 1;
        vld_d[0] = rd_xfer;
        rd_oor_d = rd_xfer && addr_oor;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= RST;
            wait_cnt_q <= 3'd0;
            ready_q    <= 1'b0;
            oor_err_q  <= 1'b0;
            vld_q      <= '0;
            rd_oor_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            oor_err_q  <= oor_err_d;
            vld_q      <= vld_d;
            rd_oor_q   <= rd_oor_d;
        end
    end

    sram_bram_array #(
        .AW (MEM_AW)
    ) u_array (
        .clk     (clk),
        .we      (wr_xfer),
        .be      (sram_be),
        .addr    (sram_addr[MEM_AW-1:0]),
        .wr_data (sram_wr_data),
        .rd_data (bram_rd_data)
    );

    // Idle stages carry zero, so the output data is already clean whenever vld is low.
    assign stage0_data = !vld_q[0] ? '0 : (rd_oor_q ? OOR_FILL : bram_rd_data);

    if (RD_LAT == 1) begin : g_no_pipe
        assign pipe_out = stage0_data;
    end else begin : g_pipe
        logic [SRAM_DW-1:0] data_d [RD_LAT-1];
        logic [SRAM_DW-1:0] data_q [RD_LAT-1];

        always_comb begin
            data_d[0] = stage0_data;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                data_d[i] = data_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < RD_LAT - 1; i++) begin
                    data_q[i] <= data_d[i];
                end
            end
        end

        assign pipe_out = data_q[RD_LAT-2];
    end

    assign sram_ready       = ready_q;
    assign sram_rd_data_vld = vld_q[RD_LAT-1];
    assign sram_rd_data     = pipe_out;
    assign oor_err          = oor_err_q;

endmodule

// File: tb/tb_sram_bram_responder.sv
// Self-checking bench: a default responder against a transaction-level model, plus a slow/long-latency instance.
module tb_sram_bram_responder;

    localparam int A_LAT = 2;
    localparam int B_LAT = 4;
    localparam int B_WS  = 3;

    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, a_rd = 0, a_clr = 0;
    logic [17:0] a_addr = '0;
    logic [1:0]  a_be = '0;
    logic [15:0] a_wd = '0;
    logic        a_ready, a_vld, a_oor;
    logic [15:0] a_rdata;

    logic        b_req = 0, b_rd = 0, b_clr = 0;
    logic [17:0] b_addr = '0;
    logic [1:0]  b_be = '0;
    logic [15:0] b_wd = '0;
    logic        b_ready, b_vld, b_oor;
    logic [15:0] b_rdata;

    sram_bram_responder #(.ADDR_W(18), .MEM_AW(12), .RD_LAT(A_LAT), .WAIT_STATES(0)) dut_a (
        .clk(clk), .reset_(reset_), .sram_req(a_req), .sram_ready(a_ready), .sram_rd(a_rd),
        .sram_addr(a_addr), .sram_be(a_be), .sram_wr_data(a_wd), .sram_rd_data_vld(a_vld),
        .sram_rd_data(a_rdata), .oor_err(a_oor), .oor_clr(a_clr)
    );

    sram_bram_responder #(.ADDR_W(18), .MEM_AW(12), .RD_LAT(B_LAT), .WAIT_STATES(B_WS)) dut_b (
        .clk(clk), .reset_(reset_), .sram_req(b_req), .sram_ready(b_ready), .sram_rd(b_rd),
        .sram_addr(b_addr), .sram_be(b_be), .sram_wr_data(b_wd), .sram_rd_data_vld(b_vld),
        .sram_rd_data(b_rdata), .oor_err(b_oor), .oor_clr(b_clr)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int a_vld_cnt = 0;
    int b_vcyc[$];
    logic [15:0] b_vdat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for dut_a: ready is high from the first edge after reset (no wait states),
    // memory is a plain array, reads are queued with their due cycle.
    typedef struct { int due; logic [15:0] data; } rd_exp_t;
    rd_exp_t     m_q[$];
    logic [15:0] m_mem [32];
    logic        m_ready = 1'b0;
    logic        m_oor = 1'b0;

    always @(posedge clk or negedge reset_) begin : model_blk
        rd_exp_t e;
        logic    is_oor;
        if (!reset_) begin
            m_ready = 1'b0;
            m_oor   = 1'b0;
            m_q.delete();
        end else begin
            is_oor = (a_addr >= 18'd4096);
            if (a_req && m_ready) begin
                if (a_rd) begin
                    e.due  = cyc + A_LAT;
                    e.data = is_oor ? 16'h0000 : m_mem[a_addr[4:0]];
                    m_q.push_back(e);
                end else if (!is_oor) begin
                    if (a_be[0]) m_mem[a_addr[4:0]][7:0]  = a_wd[7:0];
                    if (a_be[1]) m_mem[a_addr[4:0]][15:8] = a_wd[15:8];
                end
                if (is_oor) m_oor = 1'b1;
                else if (a_clr) m_oor = 1'b0;
            end else if (a_clr) begin
                m_oor = 1'b0;
            end
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("a_ready", a_ready, m_ready);
        check("a_oor_err", a_oor, m_oor);
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            check("a_rd_data_vld", a_vld, 1'b1);
            check("a_rd_data", a_rdata, m_q[0].data);
            void'(m_q.pop_front());
        end else begin
            check("a_rd_data_vld_idle", a_vld, 1'b0);
        end
        if (a_vld) a_vld_cnt++;
        if (b_vld) begin
            b_vcyc.push_back(cyc);
            b_vdat.push_back(b_rdata);
        end
    end

    // Called just after a rising edge; returns just after the edge that took the transfer.
    task automatic xfer_a(input logic rd, input logic [17:0] addr, input logic [1:0] be,
                          input logic [15:0] wd, output int t);
        bit ok;
        ok = 0;
        t  = -1;
        a_rd = rd; a_addr = addr; a_be = be; a_wd = wd; a_req = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (a_ready) begin
                ok = 1;
                t  = cyc;
            end
        end
        check("a_accept", ok, 1'b1);
        @(posedge clk); #1;
        a_req = 1'b0;
    endtask

    task automatic xfer_b(input logic rd, input logic [17:0] addr, input logic [1:0] be,
                          input logic [15:0] wd, output int t);
        bit ok;
        ok = 0;
        t  = -1;
        b_rd = rd; b_addr = addr; b_be = be; b_wd = wd; b_req = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b_ready) begin
                ok = 1;
                t  = cyc;
            end
        end
        check("b_accept", ok, 1'b1);
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    task automatic expect_read_a(input int t, input logic [15:0] exp, input string name);
        int          lat;
        logic [15:0] got;
        lat = -1;
        got = '0;
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge clk);
            if (a_vld) begin
                lat = cyc - t;
                got = a_rdata;
            end
        end
        check({name, "_latency"}, lat, A_LAT);
        check({name, "_data"}, got, exp);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        rd;
        logic [17:0] addr;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int tb_t[4];
        int cnt0;
        logic [17:0] addr;

        vecs = '{
            '{1'b0, 18'h00010, 2'b11, 16'hA55A, 16'h0000},
            '{1'b1, 18'h00010, 2'b00, 16'h0000, 16'hA55A},
            '{1'b0, 18'h00005, 2'b11, 16'h1234, 16'h0000},
            '{1'b0, 18'h00005, 2'b10, 16'hFF00, 16'h0000},
            '{1'b1, 18'h00005, 2'b00, 16'h0000, 16'hFF34},
            '{1'b0, 18'h00005, 2'b00, 16'hABCD, 16'h0000},
            '{1'b1, 18'h00005, 2'b11, 16'h0000, 16'hFF34},
            '{1'b0, 18'h00005, 2'b01, 16'h00AA, 16'h0000},
            '{1'b1, 18'h00005, 2'b00, 16'h0000, 16'hFFAA},
            '{1'b0, 18'h01000, 2'b11, 16'hBEEF, 16'h0000},
            '{1'b1, 18'h00000, 2'b00, 16'h0000, 16'h5000},
            '{1'b1, 18'h01000, 2'b00, 16'h0000, 16'h0000},
            '{1'b0, 18'h20003, 2'b11, 16'hDEAD, 16'h0000},
            '{1'b1, 18'h00003, 2'b00, 16'h0000, 16'h5003},
            '{1'b1, 18'h3FFFF, 2'b00, 16'h0000, 16'h0000},
            '{1'b0, 18'h00007, 2'b11, 16'h0F0F, 16'h0000},
            '{1'b1, 18'h00007, 2'b00, 16'h0000, 16'h0F0F}
        };

        // Reset values on both instances.
        repeat (2) begin
            @(negedge clk);
            check("rst_a_ready", a_ready, 1'b0);
            check("rst_a_vld", a_vld, 1'b0);
            check("rst_a_data", a_rdata, 16'h0000);
            check("rst_a_oor", a_oor, 1'b0);
            check("rst_b_ready", b_ready, 1'b0);
            check("rst_b_vld", b_vld, 1'b0);
        end
        @(posedge clk); #3;
        reset_ = 1'b1;
        @(negedge clk);
        check("a_ready_first_cycle_after_reset", a_ready, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) begin
            xfer_a(1'b0, 18'(i), 2'b11, 16'(16'h5000 + i), t);
        end

        foreach (vecs[i]) begin
            xfer_a(vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wd, t);
            if (vecs[i].rd) expect_read_a(t, vecs[i].exp, $sformatf("vec%0d", i));
        end

        @(negedge clk);
        check("oor_err_set", a_oor, 1'b1);
        @(posedge clk); #1;
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        @(negedge clk);
        check("oor_err_cleared", a_oor, 1'b0);
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            a_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) addr = 18'($urandom_range(4096, 262143));
            else addr = 18'($urandom_range(0, 31));
            xfer_a(1'($urandom_range(0, 1)), addr, 2'($urandom_range(0, 3)), 16'($urandom), t);
            a_clr = 1'b0;
        end
        repeat (6) begin
            @(posedge clk); #1;
        end

        // Slow instance: 3 wait states, 4-cycle read latency.
        for (int k = 0; k < 4; k++) begin
            xfer_b(1'b0, 18'(k), 2'b11, 16'(16'hC000 + k), t);
        end
        b_vcyc.delete();
        b_vdat.delete();
        for (int k = 0; k < 4; k++) begin
            xfer_b(1'b1, 18'(k), 2'b00, 16'h0000, tb_t[k]);
        end
        for (int k = 1; k < 4; k++) begin
            check($sformatf("b_ready_period%0d", k), tb_t[k] - tb_t[k-1], B_WS + 1);
        end
        repeat (10) @(negedge clk);
        check("b_vld_count", b_vcyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < b_vcyc.size()) begin
                check($sformatf("b_vld_latency%0d", k), b_vcyc[k] - tb_t[k], B_LAT);
                check($sformatf("b_rd_data%0d", k), b_vdat[k], 16'(16'hC000 + k));
            end
        end
        @(posedge clk); #1;

        // Reset while a read is in flight.
        xfer_a(1'b1, 18'h00010, 2'b11, 16'h0000, t);
        cnt0 = a_vld_cnt;
        #2;
        reset_ = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_ready", a_ready, 1'b0);
            check("midrst_vld", a_vld, 1'b0);
            check("midrst_data", a_rdata, 16'h0000);
        end
        @(posedge clk); #3;
        reset_ = 1'b1;
        @(negedge clk);
        check("midrst_ready_first_cycle", a_ready, 1'b0);
        @(negedge clk);
        check("midrst_ready_after", a_ready, 1'b1);
        repeat (6) @(negedge clk);
        check("midrst_no_vld", a_vld_cnt, cnt0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_bram_responder.md
Name: sram_bram_responder

Overview:
- Responder on the internal SRAM request interface (sram_req/sram_ready/sram_rd/sram_addr/sram_be/sram_wr_data/sram_rd_data_vld/sram_rd_data).
- Serves requests from on-chip block RAM instead of the external SRAM pins.
- Lets ram_test and other initiators run without the off-chip SRAM, or against a small scratch memory.
- Injects configurable wait states and read latency so initiators are exercised against ready throttling and delayed read return.

Parameters:
- ADDR_W, 18, width of sram_addr (matches the external SRAM word address).
- MEM_AW, 12, log2 of backing-store depth in 16-bit words (4096 words).
- RD_LAT, 2, cycles from read acceptance to sram_rd_data_vld; legal range 1..4.
- WAIT_STATES, 0, cycles sram_ready stays low after each accepted transfer; legal range 0..7.

Ports:
- clk  input  1  system clock, 100 MHz domain.
- reset_  input  1  asynchronous active-low reset.
- sram_req  input  1  initiator request valid.
- sram_ready  output  1  responder can accept; transfer occurs when sram_req && sram_ready at a rising edge.
- sram_rd  input  1  1 = read, 0 = write; qualified by the transfer.
- sram_addr  input  ADDR_W  word address.
- sram_be  input  2  byte enables for writes; bit0 = [7:0], bit1 = [15:8].
- sram_wr_data  input  16  write data.
- sram_rd_data_vld  output  1  one-cycle pulse per accepted read, in acceptance order.
- sram_rd_data  output  16  read data, valid only while sram_rd_data_vld is high.
- oor_err  output  1  sticky flag: an accepted access had sram_addr >= 2**MEM_AW.
- oor_clr  input  1  synchronous clear of oor_err.

Behaviour:
- Reset values (async assert, sync release): sram_ready=0, sram_rd_data_vld=0, sram_rd_data=0, oor_err=0, read pipeline flushed, wait counter=0. Memory contents are not reset (undefined after power-up).
- Ready FSM, states RST, ACCEPT, WAIT:
  - RST → ACCEPT on the first clock edge after reset deasserts; sram_ready is 1 only in ACCEPT.
  - ACCEPT with transfer and WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
  - ACCEPT with transfer and WAIT_STATES=0 → stay in ACCEPT; back-to-back transfers every cycle.
  - WAIT → ACCEPT when counter==0, otherwise decrement.
  - sram_req with sram_ready low is ignored; the initiator must hold request fields stable until the transfer.
- Writes:
  - Committed at the transfer edge; byte lanes gated by sram_be.
  - be=2'b00 is accepted and is a no-op.
  - No response pulse for writes.
- Reads:
  - Block RAM read issued at the transfer edge (1 cycle); result passes through RD_LAT-1 further register stages.
  - sram_rd_data_vld is high exactly RD_LAT cycles after the transfer edge.
  - sram_be is ignored; the full 16-bit word is returned.
  - Pipeline holds up to RD_LAT reads in flight; no backpressure on return.
- Ordering:
  - A write at cycle N followed by a read of the same address at cycle N+1 returns the new data.
  - Simultaneous same-cycle read/write is impossible (single request port).
- Out of range (any nonzero sram_addr[ADDR_W-1:MEM_AW]):
  - Write is dropped.
  - Read returns 16'h0000 with normal latency.
  - oor_err sets on the transfer edge.
  - If oor_clr and a new OOR transfer occur in the same cycle, set wins.
- Wait counter and latency pipeline do not wrap or overflow within the legal parameter ranges.
- Reset mid-operation: in-flight reads are discarded (no vld pulse after reset); pending wait is abandoned; sram_ready is 0 for the first cycle after release.
- Parameter checks: elaboration-time assertions on RD_LAT and WAIT_STATES ranges and MEM_AW <= ADDR_W.

Decomposition:
- Shared package sram_pkg:
  - constants SRAM_DW=16, SRAM_BEW=2, SRAM_AW=18;
  - enum for responder states {RST, ACCEPT, WAIT};
  - OOR read-fill constant 16'h0000.
- Sub-module sram_bram_array:
  - single-port, 2**MEM_AW x 16, per-byte write enables, registered read;
  - written so yosys infers SB_RAM40_4K.
- Top holds the FSM, wait counter, latency shift pipeline (vld + data) and OOR logic.

Test Plan:
- Defaults: write addr 0x00010 data 0xA55A be=11, then read 0x00010 → sram_ready held 1, vld exactly 2 cycles after the read transfer, data 0xA55A.
- Byte lanes: write 0x1234 be=11 to addr 5, write 0xFF00 be=10, read → 0xFF34; then write be=00, read → still 0xFF34.
- WAIT_STATES=3, RD_LAT=4: hold sram_req high for 4 back-to-back reads → ready pattern 1,0,0,0 repeating; 4 vld pulses each 4 cycles after its transfer, in order.
- Out of range, MEM_AW=12: write 0x1000 data 0xBEEF, then read 0x00000 and 0x1000 → addr 0 unchanged, 0x1000 returns 0x0000, oor_err=1; pulse oor_clr → oor_err=0 next cycle.
- Reset mid-flight: issue read, assert reset_ low 1 cycle later → no vld pulse at any time; sram_ready=0 during reset and in the first cycle after release, 1 thereafter.
- Write-then-read hazard: write addr 7 = 0x0F0F at cycle N, read addr 7 at cycle N+1 → returns 0x0F0F.
